// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//
// Shares a single register-file read port among NREQ requesters. A round-robin
// arbiter accepts one request at a time, drives the registered read-mux select,
// samples the mux output one cycle later and returns the data tagged with the
// id of the requester that asked for it.
//
// Transaction flow: IDLE (accept) -> READ (sample rf_data) -> RESP (hold until
// rsp_ready). At most one accept every three cycles, one transaction in flight.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid[NREQ]            per-requester request pending
//   req_addr[NREQ*AW]          register address, requester i at [i*AW +: AW]
//   req_ready[NREQ]            one-hot accept pulse (combinational, IDLE only)
//   rf_sel[AW]                 registered read-mux select
//   rf_data[DW]                read-mux output, combinational from rf_sel
//   wr_en, wr_addr, wr_data    snooped register-file write port
//   rsp_valid, rsp_id, rsp_data  response, held stable until rsp_ready
//   rsp_ready                  consumer accepts the response
//
// Build option
//   RF_BYPASS_EN  when defined, a write to the register being read in the READ
//                 cycle is forwarded into the response (wr_data replaces
//                 rf_data). When undefined the pre-write rf_data is returned
//                 and the write port is ignored.
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic [AW-1:0]        rf_sel,
    input  logic [DW-1:0]        rf_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    input  logic                 rsp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW-1:0]   r_sel;       // latched address, drives the read mux
    logic [IDW-1:0]  r_id;        // requester being served
    logic [IDW-1:0]  r_last;      // last granted requester (round-robin pointer)
    logic [IDW-1:0]  r_rsp_id;
    logic [DW-1:0]   r_rsp_data;

    logic            w_any;
    logic [IDW-1:0]  w_gnt_id;
    logic [AW-1:0]   w_gnt_addr;
    logic            w_accept;
    logic [DW-1:0]   w_rd_data;

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid requester scanning from r_last+1 upwards,
    // wrapping at NREQ.
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so no path leaves it unassigned and no latch is inferred.
    // -------------------------------------------------------------------------
    always_comb begin
        int idx;
        idx        = 0;
        w_any      = 1'b0;
        w_gnt_id   = '0;
        w_gnt_addr = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_last) + k) % NREQ;
            if (!w_any && req_valid[idx]) begin
                w_any      = 1'b1;
                w_gnt_id   = IDW'(idx);
                w_gnt_addr = req_addr[idx*AW +: AW];
            end
        end
    end

    // Data captured in the READ cycle; register 0 is forced to zero below.
`ifdef RF_BYPASS_EN
    assign w_rd_data = (wr_en && (wr_addr == r_sel)) ? wr_data : rf_data;
`else
    logic w_unused_wr;
    assign w_rd_data   = rf_data;
    assign w_unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    req_ready   = NREQ'(1) << w_gnt_id;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers. The pointer resets to NREQ-1 so requester 0 is the
    // first candidate after reset. The response is a snapshot taken in READ;
    // nothing updates it while it waits in RESP.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= '0;
            r_id       <= '0;
            r_last     <= IDW'(NREQ - 1);
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_sel  <= w_gnt_addr;
                r_id   <= w_gnt_id;
                r_last <= w_gnt_id;
            end
            if (r_state == ST_READ) begin
                r_rsp_data <= (r_sel == '0) ? '0 : w_rd_data;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign rf_sel    = r_sel;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_arbiter
//
// Directed scenarios against a behavioural 32x32 register file whose read mux
// follows rf_sel. Expected grants and responses are queued when stimulus is
// issued; two monitors compare them against req_ready pulses and accepted
// responses. Honours RF_BYPASS_EN for the forwarding expectation.
// -----------------------------------------------------------------------------
module tb_regfile_read_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ-1:0]     req_ready;
    logic [AW-1:0]       rf_sel;
    logic [DW-1:0]       rf_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                rsp_ready;

    logic [DW-1:0] regs [32];
    rsp_t          rsp_q [$];
    int            gnt_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    regfile_read_arbiter #(.NREQ(NREQ), .IDW(IDW), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rf_sel    (rf_sel),
        .rf_data   (rf_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Register-file model: combinational read mux, write at the clock edge.
    assign rf_data = regs[rf_sel];
    always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Grant monitor
    always @(negedge clk) begin
        if (rst_n && (req_ready != '0)) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_grant", 64'(req_ready), 64'h0);
            end else begin
                check("grant_onehot", 64'(req_ready), 64'(NREQ'(1) << gnt_q.pop_front()));
            end
        end
    end

    // Response monitor: compares on every accepted response.
    rsp_t exp_rsp;
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_data), 64'hDEAD_0000_0000);
            end else begin
                exp_rsp = rsp_q.pop_front();
                check("rsp_id",   64'(rsp_id),   64'(exp_rsp.id));
                check("rsp_data", 64'(rsp_data), 64'(exp_rsp.data));
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
    endtask

    // Returns the cycle number at which a grant was observed.
    task automatic wait_grant(input string name, output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) timeout_fail(name);
    endtask

    task automatic wait_rsp_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout_fail(name);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && gnt_q.size() == 0 && !rsp_valid) break;
        end
        check({name, "_drained"}, 64'(rsp_q.size() + gnt_q.size()), 64'h0);
    endtask

    initial begin
        int t0, t1;
        logic [DW-1:0] exp_fwd;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
        regs[0]   = 32'hFFFF_FFFF;
        regs[5]   = 32'hDEAD_BEEF;
        regs[7]   = 32'h1111_1111;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rsp_ready = 1'b1;

        // Reset state
        #3;
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_req_ready", 64'(req_ready), 64'h0);
        check("reset_rf_sel",    64'(rf_sel),    64'h0);
        check("reset_rsp_data",  64'(rsp_data),  64'h0);
        #19 rst_n = 1'b1;

        // Single read of R5 by requester 0: accept T, select T+1, response T+2
        @(posedge clk); #1;
        gnt_q.push_back(0);
        rsp_q.push_back('{id: 2'd0, data: 32'hDEAD_BEEF});
        set_req(0, 5'd5);
        wait_grant("t2_grant", t0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("t2_rf_sel_T1",    64'(rf_sel),    64'd5);
        check("t2_rsp_valid_T1", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        check("t2_rsp_valid_T2", 64'(rsp_valid), 64'h1);
        drain("t2");

        // Asynchronous reset while a response waits in RESP
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        gnt_q.push_back(2);
        rsp_q.push_back('{id: 2'd2, data: 32'hDEAD_BEEF});
        set_req(2, 5'd5);
        wait_grant("t1_grant", t0);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp_valid("t1_rsp_valid");
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("t1_rst_req_ready", 64'(req_ready), 64'h0);
        check("t1_rst_rsp_id",    64'(rsp_id),    64'h0);
        check("t1_rst_rsp_data",  64'(rsp_data),  64'h0);
        check("t1_rst_rf_sel",    64'(rf_sel),    64'h0);
        rsp_q.delete();
        #3 rst_n = 1'b1;
        rsp_ready = 1'b1;

        // All four requesters held: order 0,1,2,3,0,1 at a 3-cycle spacing
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            gnt_q.push_back(k % NREQ);
            rsp_q.push_back('{id: IDW'(k % NREQ), data: regs[8 + (k % NREQ)]});
        end
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(8 + i));
        t1 = -1;
        for (int k = 0; k < 6; k++) begin
            wait_grant("t3_grant", t0);
            if (k > 0 && t0 >= 0 && t1 >= 0) check("t3_spacing", 64'(t0 - t1), 64'd3);
            t1 = t0;
        end
        @(posedge clk); #1 req_valid = '0;
        drain("t3");

        // Register 0 reads zero though the mux drives all ones
        @(posedge clk); #1;
        gnt_q.push_back(3);
        rsp_q.push_back('{id: 2'd3, data: 32'h0});
        set_req(3, 5'd0);
        wait_grant("t4_grant", t0);
        @(posedge clk); #1 req_valid = '0;
        drain("t4");

        // Consumer stalls 5 cycles; a pending request and a write to the
        // same register must not disturb the held response.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        gnt_q.push_back(1);
        rsp_q.push_back('{id: 2'd1, data: 32'hDEAD_BEEF});
        set_req(1, 5'd5);
        wait_grant("t5_grant", t0);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp_valid("t5_rsp_valid");
        @(posedge clk); #1;
        gnt_q.push_back(0);
        rsp_q.push_back('{id: 2'd0, data: regs[12]});
        set_req(0, 5'd12);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hCAFE_F00D;
        @(posedge clk); #1 wr_en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(rsp_valid), 64'h1);
            check("t5_hold_id",    64'(rsp_id),    64'h1);
            check("t5_hold_data",  64'(rsp_data),  64'hDEAD_BEEF);
            check("t5_hold_ready", 64'(req_ready), 64'h0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_idle_valid", 64'(rsp_valid), 64'h0);
        check("t5_idle_grant", 64'(req_ready), 64'h1);
        @(posedge clk); #1 req_valid = '0;
        drain("t5");

        // Same-cycle write to the register being read
`ifdef RF_BYPASS_EN
        exp_fwd = 32'h1234_5678;
`else
        exp_fwd = 32'h1111_1111;
`endif
        @(posedge clk); #1;
        gnt_q.push_back(2);
        rsp_q.push_back('{id: 2'd2, data: exp_fwd});
        set_req(2, 5'd7);
        wait_grant("t6_grant", t0);
        @(posedge clk); #1;
        req_valid = '0;
        wr_en     = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 32'h1234_5678;
        @(posedge clk); #1 wr_en = 1'b0;
        drain("t6");
        check("idle_rf_sel_hold", 64'(rf_sel), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
